// File: rtl/systolic_pkg.sv
// Shared definitions for the systolic operand feeder: array geometry, FSM
// states and the accumulator range the downstream PE grid works in.
package systolic_pkg;

   localparam int N         = 4;
   localparam int DW        = 4;
   localparam int ACC_W     = 9;
   localparam int LANE_W    = $clog2(N);
   localparam int STEP_W    = $clog2(3 * N - 2);
   localparam int LAST_STEP = 3 * N - 3;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      CLEAR  = 2'd1,
      STREAM = 2'd2,
      DONE   = 2'd3
   } feeder_state_t;

   // Saturating clamp into the PE accumulator's signed ACC_W-bit range.
   function automatic int sat_acc(input int v);
      int hi;
      int lo;
      hi = (2 ** (ACC_W - 1)) - 1;
      lo = -(2 ** (ACC_W - 1));
      if (v > hi) return hi;
      if (v < lo) return lo;
      return v;
   endfunction

endpackage

// File: rtl/systolic_skew_feeder_if.sv
// Host-side bus of the skew feeder: operand write port, start strobe,
// status flags and the two skewed array edges.
interface systolic_skew_feeder_if;
   import systolic_pkg::*;

   // Strobes are single-cycle and sampled on the rising edge; a write or start
   // is taken only when dbg_state is IDLE, otherwise it is silently dropped.
   logic                  wr_en;
   logic                  wr_sel;
   logic [LANE_W-1:0]     wr_row;
   logic [LANE_W-1:0]     wr_col;
   logic [DW-1:0]         wr_data;
   logic                  start;
   logic                  busy;
   logic                  done;
   logic                  array_clr;
   logic [N*DW-1:0]       a_edge;
   logic [N*DW-1:0]       b_edge;
   feeder_state_t         dbg_state;

   modport master (
      output wr_en, wr_sel, wr_row, wr_col, wr_data, start,
      input  busy, done, array_clr, a_edge, b_edge, dbg_state
   );

   modport slave (
      input  wr_en, wr_sel, wr_row, wr_col, wr_data, start,
      output busy, done, array_clr, a_edge, b_edge, dbg_state
   );

endinterface

// File: rtl/skew_operand_bank.sv
// N x N operand register file with one diagonally skewed read per lane.
// TRANSPOSE=0 reads M[lane][k-lane] (A side), TRANSPOSE=1 reads M[k-lane][lane] (B side).
module skew_operand_bank
   import systolic_pkg::*;
#(
   parameter bit TRANSPOSE = 1'b0
)
(
   input  logic              clk,
   input  logic              reset,
   input  logic              i_wr_en,
   input  logic [LANE_W-1:0] i_wr_row,
   input  logic [LANE_W-1:0] i_wr_col,
   input  logic [DW-1:0]     i_wr_data,
   input  logic [STEP_W-1:0] i_step,
   output logic [N*DW-1:0]   o_lanes
);

   logic [DW-1:0] r_mem [N][N];

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int r = 0; r < N; r++) begin
            for (int c = 0; c < N; c++) begin
               r_mem[r][c] <= '0;
            end
         end
      end else if (i_wr_en && (int'(i_wr_row) < N) && (int'(i_wr_col) < N)) begin
         r_mem[i_wr_row][i_wr_col] <= i_wr_data;
      end
   end

   // Lane l is live while 0 <= step-l < N; outside that window it feeds zeros,
   // which is what lets the array fill and drain without extra control.
   always_comb begin : p_skew_read
      logic [STEP_W-1:0] w_diff;
      logic [LANE_W-1:0] w_idx;
      o_lanes = '0;
      w_diff  = '0;
      w_idx   = '0;
      for (int l = 0; l < N; l++) begin
         w_diff = i_step - STEP_W'(l);
         w_idx  = w_diff[LANE_W-1:0];
         if ((i_step >= STEP_W'(l)) && (w_diff < STEP_W'(N))) begin
            if (TRANSPOSE) begin
               o_lanes[l*DW +: DW] = r_mem[w_idx][LANE_W'(l)];
            end else begin
               o_lanes[l*DW +: DW] = r_mem[LANE_W'(l)][w_idx];
            end
         end
      end
   end

endmodule

// File: rtl/systolic_skew_feeder.sv
// Operand feeder for the signed systolic PE grid: clears the accumulators,
// then streams A along the left edge and B along the top edge with diagonal skew.
module systolic_skew_feeder
   import systolic_pkg::*;
(
   input  logic                    clk,
   input  logic                    reset,
   systolic_skew_feeder_if.slave   bus
);

   feeder_state_t     r_state;
   logic [STEP_W-1:0] r_step;
   logic              r_busy;
   logic              r_done;
   logic              r_clr;
   logic [N*DW-1:0]   r_a_edge;
   logic [N*DW-1:0]   r_b_edge;

   logic              w_idle;
   logic              w_wr_a;
   logic              w_wr_b;
   logic [STEP_W-1:0] w_rd_step;
   logic [N*DW-1:0]   w_a_lanes;
   logic [N*DW-1:0]   w_b_lanes;

   assign w_idle = (r_state == IDLE);
   assign w_wr_a = bus.wr_en & w_idle & ~bus.wr_sel;
   assign w_wr_b = bus.wr_en & w_idle &  bus.wr_sel;

   // The banks are read one step ahead so the edge registers show step k
   // in the same cycle the step counter holds k.
   assign w_rd_step = (r_state == STREAM) ? (r_step + STEP_W'(1)) : '0;

   skew_operand_bank #(.TRANSPOSE(1'b0)) u_bank_a (
      .clk       (clk),
      .reset     (reset),
      .i_wr_en   (w_wr_a),
      .i_wr_row  (bus.wr_row),
      .i_wr_col  (bus.wr_col),
      .i_wr_data (bus.wr_data),
      .i_step    (w_rd_step),
      .o_lanes   (w_a_lanes)
   );

   skew_operand_bank #(.TRANSPOSE(1'b1)) u_bank_b (
      .clk       (clk),
      .reset     (reset),
      .i_wr_en   (w_wr_b),
      .i_wr_row  (bus.wr_row),
      .i_wr_col  (bus.wr_col),
      .i_wr_data (bus.wr_data),
      .i_step    (w_rd_step),
      .o_lanes   (w_b_lanes)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state  <= IDLE;
         r_step   <= '0;
         r_busy   <= 1'b0;
         r_done   <= 1'b0;
         r_clr    <= 1'b0;
         r_a_edge <= '0;
         r_b_edge <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               r_done   <= 1'b0;
               r_a_edge <= '0;
               r_b_edge <= '0;
               if (bus.start) begin
                  r_state <= CLEAR;
                  r_clr   <= 1'b1;
                  r_busy  <= 1'b1;
               end
            end
            CLEAR: begin
               r_state  <= STREAM;
               r_clr    <= 1'b0;
               r_step   <= '0;
               r_a_edge <= w_a_lanes;
               r_b_edge <= w_b_lanes;
            end
            STREAM: begin
               if (r_step == STEP_W'(LAST_STEP)) begin
                  r_state  <= DONE;
                  r_busy   <= 1'b0;
                  r_done   <= 1'b1;
                  r_a_edge <= '0;
                  r_b_edge <= '0;
               end else begin
                  r_step   <= r_step + STEP_W'(1);
                  r_a_edge <= w_a_lanes;
                  r_b_edge <= w_b_lanes;
               end
            end
            DONE: begin
               r_state <= IDLE;
               r_done  <= 1'b0;
            end
            default: begin
               r_state <= IDLE;
            end
         endcase
      end
   end

   assign bus.busy      = r_busy;
   assign bus.done      = r_done;
   assign bus.array_clr = r_clr;
   assign bus.a_edge    = r_a_edge;
   assign bus.b_edge    = r_b_edge;
   assign bus.dbg_state = r_state;

endmodule

// File: tb/tb_systolic_skew_feeder.sv
// Directed bench for systolic_skew_feeder with a small behavioural PE grid
// fed from the edges, so matrix products can be checked at done.
module tb_systolic_skew_feeder;
   import systolic_pkg::*;

   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   systolic_skew_feeder_if bus();

   systolic_skew_feeder dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   int errors = 0;
   int checks = 0;

   // Behavioural PE grid: a flows right, b flows down, saturating MAC.
   int g_acc [N][N];
   int g_a   [N][N];
   int g_b   [N][N];

   function automatic int lane_val(input logic [N*DW-1:0] v, input int l);
      logic [DW-1:0] s;
      s = v[l*DW +: DW];
      return int'($signed(s));
   endfunction

   function automatic int a_in(input int i, input int j);
      return (j == 0) ? lane_val(bus.a_edge, i) : g_a[i][(j + N - 1) % N];
   endfunction

   function automatic int b_in(input int i, input int j);
      return (i == 0) ? lane_val(bus.b_edge, j) : g_b[(i + N - 1) % N][j];
   endfunction

   initial begin
      for (int i = 0; i < N; i++)
         for (int j = 0; j < N; j++) begin
            g_acc[i][j] = 0; g_a[i][j] = 0; g_b[i][j] = 0;
         end
   end

   always @(posedge clk) begin
      for (int i = 0; i < N; i++) begin
         for (int j = 0; j < N; j++) begin
            if (reset || bus.array_clr) begin
               g_acc[i][j] <= 0;
               g_a[i][j]   <= 0;
               g_b[i][j]   <= 0;
            end else begin
               g_acc[i][j] <= sat_acc(g_acc[i][j] + a_in(i, j) * b_in(i, j));
               g_a[i][j]   <= a_in(i, j);
               g_b[i][j]   <= b_in(i, j);
            end
         end
      end
   end

   // Per-cycle capture of a run; index = cycles after the start edge.
   logic [N*DW-1:0] cap_a    [0:29];
   logic [N*DW-1:0] cap_b    [0:29];
   logic            cap_busy [0:29];
   logic            cap_done [0:29];
   logic            cap_clr  [0:29];
   feeder_state_t   cap_st   [0:29];
   int done_cnt;
   int done_at;
   int last_done;
   int snap [N][N];

   task automatic write_op(input bit sel, input int r, input int c, input logic [DW-1:0] d);
      bus.wr_en   = 1'b1;
      bus.wr_sel  = sel;
      bus.wr_row  = LANE_W'(r);
      bus.wr_col  = LANE_W'(c);
      bus.wr_data = d;
      @(posedge clk); #1;
      bus.wr_en   = 1'b0;
   endtask

   // kind: 0 none, 1 write A[0][0]=5 plus start, 2 reset, 3 start only;
   // injected during cycles inj_from..inj_to.
   task automatic run(input int kind, input int inj_from, input int inj_to,
                      input bit wr_with_start, input logic [DW-1:0] wdata);
      done_cnt = 0; done_at = -1; last_done = -1;
      if (wr_with_start) begin
         bus.wr_en = 1'b1; bus.wr_sel = 1'b0;
         bus.wr_row = LANE_W'(3); bus.wr_col = LANE_W'(3); bus.wr_data = wdata;
      end
      bus.start = 1'b1;
      @(posedge clk); #1;
      bus.start = 1'b0; bus.wr_en = 1'b0;
      for (int cyc = 1; cyc < 30; cyc++) begin
         if (cyc >= inj_from && cyc <= inj_to) begin
            if (kind == 1) begin
               bus.wr_en = 1'b1; bus.wr_sel = 1'b0; bus.wr_row = '0; bus.wr_col = '0;
               bus.wr_data = 4'd5; bus.start = 1'b1;
            end else if (kind == 2) begin
               reset = 1'b1;
            end else if (kind == 3) begin
               bus.start = 1'b1;
            end
         end
         @(negedge clk);
         cap_a[cyc] = bus.a_edge;  cap_b[cyc] = bus.b_edge;
         cap_busy[cyc] = bus.busy; cap_done[cyc] = bus.done;
         cap_clr[cyc] = bus.array_clr; cap_st[cyc] = bus.dbg_state;
         if (bus.done === 1'b1) begin
            done_cnt++;
            last_done = cyc;
            if (done_at < 0) begin
               done_at = cyc;
               snap = g_acc;
            end
         end
         @(posedge clk); #1;
         reset = 1'b0; bus.wr_en = 1'b0; bus.start = 1'b0;
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      @(negedge clk);
      checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", bus.busy); end
      checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", bus.done); end
      checks++; if (bus.array_clr !== 1'b0) begin errors++; $display("FAIL reset_clr: got %b expected 0", bus.array_clr); end
      checks++; if (bus.a_edge !== 16'h0000) begin errors++; $display("FAIL reset_a_edge: got %h expected 0000", bus.a_edge); end
      checks++; if (bus.b_edge !== 16'h0000) begin errors++; $display("FAIL reset_b_edge: got %h expected 0000", bus.b_edge); end
      checks++; if (bus.dbg_state !== IDLE) begin errors++; $display("FAIL reset_state: got %0d expected 0", bus.dbg_state); end
      @(posedge clk); #1;
      reset = 1'b0;
      @(posedge clk); #1;
      @(negedge clk);
      checks++; if (bus.dbg_state !== IDLE) begin errors++; $display("FAIL post_reset_state: got %0d expected 0", bus.dbg_state); end
   endtask

   task automatic test_identity();
      for (int r = 0; r < N; r++)
         for (int c = 0; c < N; c++) begin
            write_op(1'b0, r, c, (r == c) ? 4'd1 : 4'd0);
            write_op(1'b1, r, c, DW'(r * 4 + c - 8));
         end
      run(0, 0, -1, 1'b0, '0);
      checks++; if (cap_clr[1] !== 1'b1) begin errors++; $display("FAIL id_clear: got %b expected 1", cap_clr[1]); end
      checks++; if (cap_busy[1] !== 1'b1) begin errors++; $display("FAIL id_busy_first: got %b expected 1", cap_busy[1]); end
      checks++; if (cap_a[1] !== 16'h0000) begin errors++; $display("FAIL id_clear_edge: got %h expected 0000", cap_a[1]); end
      checks++; if (cap_a[2] !== 16'h0001) begin errors++; $display("FAIL id_a_step0: got %h expected 0001", cap_a[2]); end
      checks++; if (cap_b[2] !== 16'h0008) begin errors++; $display("FAIL id_b_step0: got %h expected 0008", cap_b[2]); end
      checks++; if (cap_b[5] !== 16'hBE14) begin errors++; $display("FAIL id_b_step3: got %h expected be14", cap_b[5]); end
      checks++; if (cap_busy[11] !== 1'b1) begin errors++; $display("FAIL id_busy_last: got %b expected 1", cap_busy[11]); end
      checks++; if (cap_busy[12] !== 1'b0) begin errors++; $display("FAIL id_busy_done: got %b expected 0", cap_busy[12]); end
      checks++; if (done_at !== 12) begin errors++; $display("FAIL id_done_latency: got %0d expected 12", done_at); end
      checks++; if (done_cnt !== 1) begin errors++; $display("FAIL id_done_count: got %0d expected 1", done_cnt); end
      for (int i = 0; i < N; i++)
         for (int j = 0; j < N; j++) begin
            checks++;
            if (snap[i][j] !== i * 4 + j - 8) begin
               errors++; $display("FAIL id_c[%0d][%0d]: got %0d expected %0d", i, j, snap[i][j], i * 4 + j - 8);
            end
         end
   endtask

   task automatic test_edge_seq();
      int nz;
      for (int r = 0; r < N; r++)
         for (int c = 0; c < N; c++) begin
            write_op(1'b0, r, c, DW'(r * 4 + c));
            write_op(1'b1, r, c, 4'd0);
         end
      run(0, 0, -1, 1'b0, '0);
      checks++; if (cap_a[2] !== 16'h0000) begin errors++; $display("FAIL seq_step0: got %h expected 0000", cap_a[2]); end
      checks++; if (cap_a[3] !== 16'h0041) begin errors++; $display("FAIL seq_step1: got %h expected 0041", cap_a[3]); end
      checks++; if (cap_a[5] !== 16'hC963) begin errors++; $display("FAIL seq_step3: got %h expected c963", cap_a[5]); end
      checks++; if (cap_a[8] !== 16'hF000) begin errors++; $display("FAIL seq_step6: got %h expected f000", cap_a[8]); end
      checks++; if (cap_a[11] !== 16'h0000) begin errors++; $display("FAIL seq_step9: got %h expected 0000", cap_a[11]); end
      nz = 0;
      for (int c = 1; c < 30; c++) if (cap_b[c] !== 16'h0000) nz++;
      checks++; if (nz !== 0) begin errors++; $display("FAIL seq_b_zero: got %0d nonzero cycles expected 0", nz); end
   endtask

   task automatic test_extreme();
      for (int r = 0; r < N; r++)
         for (int c = 0; c < N; c++) begin
            write_op(1'b0, r, c, 4'b1000);
            write_op(1'b1, r, c, 4'b1000);
         end
      run(0, 0, -1, 1'b0, '0);
      checks++; if (cap_a[2] !== 16'h0008) begin errors++; $display("FAIL ext_a_step0: got %h expected 0008", cap_a[2]); end
      checks++; if (cap_a[5] !== 16'h8888) begin errors++; $display("FAIL ext_a_step3: got %h expected 8888", cap_a[5]); end
      checks++; if (cap_b[5] !== 16'h8888) begin errors++; $display("FAIL ext_b_step3: got %h expected 8888", cap_b[5]); end
      checks++; if (cap_a[8] !== 16'h8000) begin errors++; $display("FAIL ext_a_step6: got %h expected 8000", cap_a[8]); end
      checks++; if (cap_b[10] !== 16'h0000) begin errors++; $display("FAIL ext_b_step8: got %h expected 0000", cap_b[10]); end
      checks++; if (done_at !== 12) begin errors++; $display("FAIL ext_done_latency: got %0d expected 12", done_at); end
      for (int i = 0; i < N; i++)
         for (int j = 0; j < N; j++) begin
            checks++;
            if (snap[i][j] !== 255) begin
               errors++; $display("FAIL ext_c[%0d][%0d]: got %0d expected 255", i, j, snap[i][j]);
            end
         end
   endtask

   task automatic test_busy_ignored();
      run(1, 5, 5, 1'b0, '0);
      checks++; if (done_cnt !== 1) begin errors++; $display("FAIL busy_done_count: got %0d expected 1", done_cnt); end
      checks++; if (done_at !== 12) begin errors++; $display("FAIL busy_done_latency: got %0d expected 12", done_at); end
      run(0, 0, -1, 1'b0, '0);
      checks++; if (cap_a[2] !== 16'h0008) begin errors++; $display("FAIL busy_a00_kept: got %h expected 0008", cap_a[2]); end
      checks++; if (snap[0][0] !== 255) begin errors++; $display("FAIL busy_c00: got %0d expected 255", snap[0][0]); end
   endtask

   task automatic test_back_to_back();
      run(3, 12, 13, 1'b0, '0);
      checks++; if (cap_done[12] !== 1'b1) begin errors++; $display("FAIL b2b_first_done: got %b expected 1", cap_done[12]); end
      checks++; if (cap_clr[13] !== 1'b0) begin errors++; $display("FAIL b2b_start_in_done: got %b expected 0", cap_clr[13]); end
      checks++; if (cap_clr[14] !== 1'b1) begin errors++; $display("FAIL b2b_restart_clear: got %b expected 1", cap_clr[14]); end
      checks++; if (done_cnt !== 2) begin errors++; $display("FAIL b2b_done_count: got %0d expected 2", done_cnt); end
      checks++; if (last_done !== 25) begin errors++; $display("FAIL b2b_second_done: got %0d expected 25", last_done); end
   endtask

   task automatic test_same_cycle_write();
      run(0, 0, -1, 1'b1, 4'd7);
      checks++; if (cap_a[8] !== 16'h7000) begin errors++; $display("FAIL same_a_step6: got %h expected 7000", cap_a[8]); end
      checks++; if (cap_a[5] !== 16'h8888) begin errors++; $display("FAIL same_a_step3: got %h expected 8888", cap_a[5]); end
      checks++; if (snap[3][3] !== 136) begin errors++; $display("FAIL same_c33: got %0d expected 136", snap[3][3]); end
      checks++; if (snap[3][0] !== 136) begin errors++; $display("FAIL same_c30: got %0d expected 136", snap[3][0]); end
      checks++; if (snap[0][0] !== 255) begin errors++; $display("FAIL same_c00: got %0d expected 255", snap[0][0]); end
   endtask

   task automatic test_reset_mid_run();
      int nz;
      run(2, 6, 6, 1'b0, '0);
      checks++; if (cap_a[6] !== 16'h8880) begin errors++; $display("FAIL rst_a_step4: got %h expected 8880", cap_a[6]); end
      checks++; if (cap_b[6] !== 16'h8880) begin errors++; $display("FAIL rst_b_step4: got %h expected 8880", cap_b[6]); end
      checks++; if (cap_a[7] !== 16'h0000) begin errors++; $display("FAIL rst_a_after: got %h expected 0000", cap_a[7]); end
      checks++; if (cap_b[7] !== 16'h0000) begin errors++; $display("FAIL rst_b_after: got %h expected 0000", cap_b[7]); end
      checks++; if (cap_busy[7] !== 1'b0) begin errors++; $display("FAIL rst_busy_after: got %b expected 0", cap_busy[7]); end
      checks++; if (cap_st[7] !== IDLE) begin errors++; $display("FAIL rst_state_after: got %0d expected 0", cap_st[7]); end
      checks++; if (done_cnt !== 0) begin errors++; $display("FAIL rst_no_done: got %0d expected 0", done_cnt); end
      run(0, 0, -1, 1'b0, '0);
      nz = 0;
      for (int c = 1; c < 30; c++) if (cap_a[c] !== 16'h0000 || cap_b[c] !== 16'h0000) nz++;
      checks++; if (nz !== 0) begin errors++; $display("FAIL rst_cleared_mats: got %0d nonzero cycles expected 0", nz); end
      checks++; if (done_at !== 12) begin errors++; $display("FAIL rst_rerun_done: got %0d expected 12", done_at); end
   endtask

   initial begin
      bus.wr_en = 1'b0; bus.wr_sel = 1'b0; bus.wr_row = '0; bus.wr_col = '0;
      bus.wr_data = '0; bus.start = 1'b0;
      test_reset();
      test_identity();
      test_edge_seq();
      test_extreme();
      test_busy_ignored();
      test_back_to_back();
      test_same_cycle_write();
      test_reset_mid_run();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/systolic_skew_feeder.md
# systolic_skew_feeder

Operand feeder that sits directly upstream of the 4-bit signed systolic PE grid. It holds one N×N matrix A and one N×N matrix B of 4-bit two's-complement operands, loaded over a simple write port. On `start` it clears the grid's accumulators, then drives the left (A) and top (B) array edges with diagonally skewed operands so every PE(i,j) accumulates C[i][j] = Σk A[i][k]·B[k][j]. It then pulses `done` when all results are final in the PEs' `out_c` registers.

## Interface
Parameters:
- `N`, 4, array dimension (rows = cols = N)
- `DW`, 4, operand width (two's complement)

Ports:
- `clk`  in  1  clock
- `reset`  in  1  reset, synchronous, active-high
- `wr_en`  in  1  operand write strobe
- `wr_sel`  in  1  0 = write A, 1 = write B
- `wr_row`  in  $clog2(N)  row index
- `wr_col`  in  $clog2(N)  column index
- `wr_data`  in  DW  operand value
- `start`  in  1  begin multiply (single-cycle strobe)
- `busy`  out  1  high from CLEAR through the last STREAM cycle
- `done`  out  1  one-cycle pulse: grid results final
- `array_clr`  out  1  drives the PE grid `reset` (accumulator clear)
- `a_edge`  out  N*DW  lane i = bits [DW*i+DW-1 : DW*i], to `in_a` of PE(i,0)
- `b_edge`  out  N*DW  lane j, same packing, to `in_b` of PE(0,j)

## Operation
- FSM states: IDLE → CLEAR → STREAM → DONE → IDLE.
- IDLE: accepts writes and `start`; edges = 0; `array_clr` = 0.
- Writes are accepted only in IDLE. `wr_en` in any other state is ignored. A write with `wr_row` or `wr_col` ≥ N is ignored.
- `start` is accepted only in IDLE and is ignored otherwise. If `wr_en` and `start` arrive in the same IDLE cycle, the write is committed and is included in the run.
- CLEAR: one cycle with `array_clr` = 1 and edges = 0.
- STREAM: step counter k runs 0 … 3N-3 (3N-2 cycles).
  - a_edge lane i = A[i][k-i] when 0 ≤ k-i < N, else 0.
  - b_edge lane j = B[k-j][j] when 0 ≤ k-j < N, else 0.
  - Trailing zero steps are the drain phase. Zero operands add nothing to the accumulators.
- DONE: `done` = 1 for one cycle, edges = 0, `busy` = 0; next state is IDLE.
- Matrices persist across runs. Reset clears both matrices to 0.
- The block performs no arithmetic. Operand values pass through bit-exact, including -8 (4'b1000).

## Timing
- All outputs are registered. On reset: `busy` = 0, `done` = 0, `array_clr` = 0, `a_edge` = 0, `b_edge` = 0, FSM = IDLE.
- If `start` is sampled at edge c:
  - CLEAR is visible in cycle c+1.
  - STREAM step k is visible in cycle c+2+k.
  - `done` is visible in cycle c+3N. For N = 4 that is c+12.
- `busy` is 1 in cycles c+1 … c+3N-1.
- The operand pair for PE(i,j) step k' reaches that PE at stream step i+j+k'. The last accumulate happens at the edge ending step 3N-3, so `out_c` is final when `done` is high.
- Reset mid-run: the cycle after reset, all outputs = 0 and FSM = IDLE. No `done` pulse is issued, and matrix contents are cleared.
- Back-to-back runs: `start` in the `done` cycle is ignored (state ≠ IDLE). The earliest new start is the cycle after `done`.

## Structure
- Shared package `systolic_pkg` holds:
  - `N`, `DW`, and the accumulator width 9;
  - the `feeder_state_t` enum {IDLE, CLEAR, STREAM, DONE};
  - a `lane` index helper constant.
- Sub-module `skew_operand_bank`, instantiated twice:
  - N×N DW-bit register file with a write port;
  - one skewed read per lane for step k;
  - a `TRANSPOSE` parameter selects row-major (A) or column-major (B) diagonal indexing.
- Top level holds the FSM, the step counter, and the output registers.

## Test plan
- Identity × B: A = I, B[r][c] = r*4+c-8 for N = 4. Run, sample grid `out_c` at `done` → C[i][j] = B[i][j]. `done` arrives exactly 12 cycles after `start`.
- Edge sequencing: A[i][k] = i*4+k (masked to 4 bits), B = 0. Check `a_edge` per step.
  - Step 0: lane 0 = A[0][0], lanes 1–3 = 0.
  - Step 3: lanes = A[0][3], A[1][2], A[2][1], A[3][0].
  - Step 9: all lanes 0.
- Extreme operands: A = B = all -8 → every edge lane carries 4'b1000 during its valid window. The grid reports saturated 9'h0FF because 4·64 overflows.
- Ignored requests during busy: `wr_en` with A[0][0] = 5, and a second `start`, both issued mid-STREAM → A[0][0] unchanged, one `done` only, still at start+12.
- Same-cycle write+start: write A[3][3] = 7 with `start` → a_edge lane 3 = 7 at step 6.
- Reset at STREAM step 4 → next cycle all outputs 0. No `done` follows. A subsequent run with no writes streams all zeros.
